// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - word request/response port between a requester and the data memory arbiter
interface data_memory_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input  ack, rdata, err);
    modport slave  (input  req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port arbiter/sequencer for the single-port data memory (option: MEM_ARB_ROUND_ROBIN_EN)
module data_memory_arbiter #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    data_memory_arbiter_if.slave p0,
    data_memory_arbiter_if.slave p1,
    output logic                 o_mem_write,
    output logic                 o_mem_read,
    output logic [31:0]          o_mem_address,
    output logic [DATA_W-1:0]    o_mem_write_data,
    input  logic [DATA_W-1:0]    i_mem_result
);
    localparam logic [31:0] LP_DEPTH = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_owner;
    logic              r_we;
    logic              r_err;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              r_p0_err;
    logic              r_p1_err;

    logic              w_any_req;
    logic              w_grant;
    logic              w_in_range;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_p0_ack;
    logic              w_p1_ack;

    assign w_any_req   = p0.req | p1.req;
    assign w_in_range  = (r_addr < LP_DEPTH);
    // Writes and rejected addresses return zero data
    assign w_resp_data = (r_we || r_err) ? '0 : i_mem_result;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // On contention the port that was not granted last wins
    always_comb begin
        w_grant = ~p0.req;
        if (p0.req && p1.req) begin
            w_grant = ~r_last_grant;
        end
    end

    // Last-grant pointer moves on every grant; reset value lets port 0 win first
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_grant <= w_grant;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it requests
    always_comb begin
        w_grant = ~p0.req;
    end
`endif

    // FSM state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, one-cycle memory strobes and ack decode
    always_comb begin
        w_next_state     = r_state;
        o_mem_write      = 1'b0;
        o_mem_read       = 1'b0;
        o_mem_address    = '0;
        o_mem_write_data = '0;
        w_p0_ack         = 1'b0;
        w_p1_ack         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_in_range) begin
                    o_mem_address = r_addr;
                    o_mem_write   = r_we;
                    o_mem_read    = ~r_we;
                    if (r_we) begin
                        o_mem_write_data = r_wdata;
                    end
                end
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_p0_ack     = ~r_owner;
                w_p1_ack     = r_owner;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Latch the winning request, flag bad addresses, keep per-port response
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            r_p0_err   <= 1'b0;
            r_p1_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant;
                        r_we    <= w_grant ? p1.we    : p0.we;
                        r_addr  <= w_grant ? p1.addr  : p0.addr;
                        r_wdata <= w_grant ? p1.wdata : p0.wdata;
                        r_err   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_err <= ~w_in_range;
                end
                S_RESP: begin
                    if (r_owner) begin
                        r_p1_rdata <= w_resp_data;
                        r_p1_err   <= r_err;
                    end else begin
                        r_p0_rdata <= w_resp_data;
                        r_p0_err   <= r_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response is live during the ack cycle, then held until the next ack
    assign p0.ack   = w_p0_ack;
    assign p1.ack   = w_p1_ack;
    assign p0.rdata = w_p0_ack ? w_resp_data : r_p0_rdata;
    assign p1.rdata = w_p1_ack ? w_resp_data : r_p1_rdata;
    assign p0.err   = w_p0_ack ? r_err : r_p0_err;
    assign p1.err   = w_p1_ack ? r_err : r_p1_err;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - randomized self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;
    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        mem_init = 1'b0;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_result = '0;
    logic [31:0] mem_array [0:31];
    logic [31:0] ref_mem   [0:31];
    logic [31:0] hold_rdata [0:1];
    logic        hold_err   [0:1];
    int          n_pass     = 0;
    int          n_total    = 0;
    int          model_last = 1;

    data_memory_arbiter_if #(.DATA_W(32)) u_p0 ();
    data_memory_arbiter_if #(.DATA_W(32)) u_p1 ();

    data_memory_arbiter #(.DATA_W(32), .DEPTH(32)) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .p0               (u_p0),
        .p1               (u_p1),
        .o_mem_write      (mem_write),
        .o_mem_read       (mem_read),
        .o_mem_address    (mem_address),
        .o_mem_write_data (mem_write_data),
        .i_mem_result     (mem_result)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory: result one cycle after mem_read
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem_array[i] <= ref_mem[i];
        end else begin
            if (mem_write) mem_array[mem_address[4:0]] <= mem_write_data;
            if (mem_read)  mem_result <= mem_array[mem_address[4:0]];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic get_ack(input int p);
        return (p == 0) ? u_p0.ack : u_p1.ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? u_p0.rdata : u_p1.rdata;
    endfunction

    function automatic logic get_err(input int p);
        return (p == 0) ? u_p0.err : u_p1.err;
    endfunction

    task automatic drive_port(input int p, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            u_p0.req = req; u_p0.we = we; u_p0.addr = addr; u_p0.wdata = wdata;
        end else begin
            u_p1.req = req; u_p1.we = we; u_p1.addr = addr; u_p1.wdata = wdata;
        end
    endtask

    // Arbitration rule: which port is granted given the set of requesters
    function automatic int model_pick(input logic r0, input logic r1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (r0 && r1) return (model_last == 1) ? 0 : 1;
`else
        if (r0 && r1) return 0;
`endif
        return r0 ? 0 : 1;
    endfunction

    // Word memory of DEPTH=32 with bounds rejection
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err);
        err   = (addr >= 32'd32);
        rdata = '0;
        if (!err) begin
            if (we) ref_mem[addr[4:0]] = wdata;
            else    rdata = ref_mem[addr[4:0]];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, 31));
        else if (r == 7) return 32'd32 + 32'($urandom_range(0, 5));
        else if (r == 8) return $urandom;
        else             return 32'd31;
    endfunction

    task automatic test_reset();
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
        rst_n    = 1'b0;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_write, mem_read, u_p0.ack, u_p1.ack, u_p0.err, u_p1.err} !== 6'b0) begin
            $display("FAIL reset_strobes got=%b exp=000000",
                     {mem_write, mem_read, u_p0.ack, u_p1.ack, u_p0.err, u_p1.err});
        end else n_pass++;
        n_total++;
        if ({mem_address, mem_write_data} !== 64'h0) begin
            $display("FAIL reset_mem_bus got=%h exp=0", {mem_address, mem_write_data});
        end else n_pass++;
        n_total++;
        if ({u_p0.rdata, u_p1.rdata} !== 64'h0) begin
            $display("FAIL reset_rdata got=%h exp=0", {u_p0.rdata, u_p1.rdata});
        end else n_pass++;
        rst_n = 1'b1;
        model_last = 1;
        hold_rdata[0] = '0; hold_rdata[1] = '0;
        hold_err[0] = 1'b0; hold_err[1] = 1'b0;
    endtask

    task automatic test_abort_mid_issue();
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b1, 32'd10, 32'h1234_5678);
        @(posedge clk); #1;
        n_total++;
        if (mem_write !== 1'b1) $display("FAIL abort_pre_strobe got=%b exp=1", mem_write);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({mem_write, mem_read, u_p0.ack, u_p1.ack} !== 4'b0) begin
            $display("FAIL abort_strobes got=%b exp=0000", {mem_write, mem_read, u_p0.ack, u_p1.ack});
        end else n_pass++;
        n_total++;
        if ({mem_address, mem_write_data} !== 64'h0) begin
            $display("FAIL abort_mem_bus got=%h exp=0", {mem_address, mem_write_data});
        end else n_pass++;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        model_last = 1;
        hold_rdata[0] = '0; hold_rdata[1] = '0;
        hold_err[0] = 1'b0; hold_err[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if ({u_p0.ack, u_p1.ack, mem_write, mem_read} !== 4'b0) begin
                $display("FAIL abort_quiet cyc=%0d got=%b exp=0000", i,
                         {u_p0.ack, u_p1.ack, mem_write, mem_read});
            end else n_pass++;
        end
    endtask

    // One request on one port; checks strobe cycle, ack cycle and response
    task automatic run_one(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [1:0]  exp_strobe;
        logic        exp_ack;
        model_last = p;
        model_apply(we, addr, wdata, exp_rdata, exp_err);
        exp_strobe = exp_err ? 2'b00 : (we ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        drive_port(p, 1'b1, we, addr, wdata);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ack = (i == 2);
            if (i == 1) begin
                n_total++;
                if ({mem_write, mem_read} !== exp_strobe) begin
                    $display("FAIL one_strobe p=%0d addr=%h got=%b exp=%b", p, addr, {mem_write, mem_read}, exp_strobe);
                end else n_pass++;
                if (!exp_err) begin
                    n_total++;
                    if (mem_address !== addr) $display("FAIL one_addr got=%h exp=%h", mem_address, addr);
                    else n_pass++;
                    if (we) begin
                        n_total++;
                        if (mem_write_data !== wdata) $display("FAIL one_wdata got=%h exp=%h", mem_write_data, wdata);
                        else n_pass++;
                    end
                end
            end
            n_total++;
            if (get_ack(p) !== exp_ack) $display("FAIL one_ack p=%0d cyc=%0d got=%b exp=%b", p, i, get_ack(p), exp_ack);
            else n_pass++;
            n_total++;
            if (get_ack(1 - p) !== 1'b0) $display("FAIL one_other_ack cyc=%0d got=%b exp=0", i, get_ack(1 - p));
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (get_rdata(p) !== exp_rdata) $display("FAIL one_rdata p=%0d got=%h exp=%h", p, get_rdata(p), exp_rdata);
                else n_pass++;
                n_total++;
                if (get_err(p) !== exp_err) $display("FAIL one_err p=%0d got=%b exp=%b", p, get_err(p), exp_err);
                else n_pass++;
                n_total++;
                if ({mem_write, mem_read, mem_address} !== 34'h0) begin
                    $display("FAIL one_idle_bus got=%h exp=0", {mem_write, mem_read, mem_address});
                end else n_pass++;
                drive_port(p, 1'b0, 1'b0, '0, '0);
            end
        end
        hold_rdata[p] = exp_rdata;
        hold_err[p]   = exp_err;
    endtask

    // Requests on one or both ports at once; checks grant order and responses
    task automatic run_pair(input logic r0, input logic r1,
                            input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic we1, input logic [31:0] a1, input logic [31:0] d1);
        int          order [0:1];
        logic [31:0] er    [0:1];
        logic        ee    [0:1];
        int          n_exp;
        int          n_seen;
        n_exp = int'(r0) + int'(r1);
        for (int k = 0; k < n_exp; k++) begin
            order[k] = (k == 0) ? model_pick(r0, r1) : 1 - order[0];
            model_last = order[k];
            if (order[k] == 0) model_apply(we0, a0, d0, er[k], ee[k]);
            else               model_apply(we1, a1, d1, er[k], ee[k]);
        end
        @(posedge clk); #1;
        if (r0) drive_port(0, 1'b1, we0, a0, d0);
        if (r1) drive_port(1, 1'b1, we1, a1, d1);
        n_seen = 0;
        for (int i = 0; i < 16 && n_seen < n_exp; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p) === 1'b1) begin
                    n_total++;
                    if (n_seen >= n_exp) begin
                        $display("FAIL pair_extra_ack got=p%0d exp=none", p);
                    end else if (order[n_seen] != p) begin
                        $display("FAIL pair_order idx=%0d got=p%0d exp=p%0d", n_seen, p, order[n_seen]);
                    end else begin
                        n_pass++;
                        n_total++;
                        if (get_rdata(p) !== er[n_seen]) $display("FAIL pair_rdata p=%0d got=%h exp=%h", p, get_rdata(p), er[n_seen]);
                        else n_pass++;
                        n_total++;
                        if (get_err(p) !== ee[n_seen]) $display("FAIL pair_err p=%0d got=%b exp=%b", p, get_err(p), ee[n_seen]);
                        else n_pass++;
                        hold_rdata[p] = er[n_seen];
                        hold_err[p]   = ee[n_seen];
                    end
                    n_seen++;
                    drive_port(p, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        n_total++;
        if (n_seen != n_exp) $display("FAIL pair_ack_count got=%0d exp=%0d", n_seen, n_exp);
        else n_pass++;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            n_total++;
            if ({get_rdata(p), get_err(p)} !== {hold_rdata[p], hold_err[p]}) begin
                $display("FAIL pair_hold p=%0d got=%h/%b exp=%h/%b", p, get_rdata(p), get_err(p), hold_rdata[p], hold_err[p]);
            end else n_pass++;
        end
    endtask

    task automatic test_write_read();
        run_one(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        run_one(0, 1'b0, 32'd5, 32'h0);
        n_total++;
        if (hold_rdata[0] !== 32'hDEAD_BEEF || u_p0.rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL wr_rd_readback got=%h exp=deadbeef", u_p0.rdata);
        end else n_pass++;
    endtask

    task automatic test_addr_error();
        run_one(1, 1'b0, 32'd32, 32'h0);
        run_one(1, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
        run_one(0, 1'b0, 32'd31, 32'h0);
        run_one(1, 1'b1, 32'h0000_0020, 32'h5A5A_5A5A);
    endtask

    task automatic test_arbitration();
        run_pair(1'b1, 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 32'd7, 32'h0);
        run_pair(1'b1, 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 32'd7, 32'h0);
    endtask

    task automatic test_continuous();
        int          exp_port [0:3];
        logic [31:0] er       [0:3];
        logic [31:0] a        [0:1];
        logic        ee;
        int          acks;
        int          last_cyc;
        a[0] = 32'($urandom_range(0, 31));
        a[1] = 32'($urandom_range(0, 31));
        for (int k = 0; k < 4; k++) begin
            exp_port[k] = model_pick(1'b1, 1'b1);
            model_last  = exp_port[k];
            model_apply(1'b0, a[exp_port[k]], '0, er[k], ee);
        end
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b0, a[0], '0);
        drive_port(1, 1'b1, 1'b0, a[1], '0);
        acks = 0;
        last_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p) === 1'b1) begin
                    n_total++;
                    if (acks >= 4 || exp_port[acks] != p) begin
                        $display("FAIL cont_order idx=%0d got=p%0d exp=p%0d", acks, p, (acks < 4) ? exp_port[acks] : -1);
                    end else begin
                        n_pass++;
                        n_total++;
                        if (get_rdata(p) !== er[acks]) $display("FAIL cont_rdata idx=%0d got=%h exp=%h", acks, get_rdata(p), er[acks]);
                        else n_pass++;
                    end
                    n_total++;
                    if ((acks == 0 && i != 2) || (acks > 0 && i - last_cyc != 3)) begin
                        $display("FAIL cont_spacing idx=%0d got=cyc%0d exp=cyc%0d", acks, i, 2 + 3 * acks);
                    end else n_pass++;
                    last_cyc = i;
                    acks++;
                end
            end
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        n_total++;
        if (acks != 4) $display("FAIL cont_ack_count got=%0d exp=4", acks);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            hold_rdata[exp_port[k]] = er[k];
            hold_err[exp_port[k]]   = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_early_drop();
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          acks;
        model_last = 0;
        model_apply(1'b1, 32'd0, 32'd9, exp_rdata, exp_err);
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b1, 32'd0, 32'd9);
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        acks = 0;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            if (u_p0.ack === 1'b1) begin
                acks++;
                n_total++;
                if (i != 2 || u_p0.err !== 1'b0 || u_p0.rdata !== 32'h0) begin
                    $display("FAIL drop_ack cyc=%0d got=%b/%h exp=cyc2 0/0", i, u_p0.err, u_p0.rdata);
                end else n_pass++;
            end
        end
        n_total++;
        if (acks != 1) $display("FAIL drop_ack_count got=%0d exp=1", acks);
        else n_pass++;
        hold_rdata[0] = exp_rdata;
        hold_err[0]   = exp_err;
        run_one(0, 1'b0, 32'd0, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0] m;
        for (int it = 0; it < 30; it++) begin
            m = 2'($urandom_range(1, 3));
            run_pair(m[0], m[1],
                     1'($urandom_range(0, 1)), rand_addr(), $urandom,
                     1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_abort_mid_issue();
        test_write_read();
        test_addr_error();
        test_arbitration();
        test_continuous();
        test_early_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
